// File: rtl/flow_led_ctrl.sv
// flow_led_ctrl
//   Running-light controller for the board LED bank. A one-hot pattern
//   advances once per programmable step interval. There are four display
//   modes: rotate left, rotate right, bounce and blink-all.
//
//   Parameters
//     LED_NUM      number of LEDs driven (2..32)
//     TICK_CYCLES  clock cycles per step at speed 0 (>= 8, fits in 32 bits)
//
//   Ports
//     clk    in   system clock, rising edge
//     rst_n  in   synchronous active-low reset
//     mode   in   00 rotate left, 01 rotate right, 10 bounce, 11 blink-all
//     speed  in   step interval = TICK_CYCLES >> speed
//     pause  in   freezes the prescaler and the pattern
//     led    out  registered LED drive, 1 = on
//     tick   out  registered one-cycle strobe, high when led shows a new step
module flow_led_ctrl #(
  parameter int LED_NUM     = 4,
  parameter int TICK_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               tick
);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [31:0]        TICK_BASE = 32'(TICK_CYCLES);
  localparam logic [LED_NUM-1:0] LED_FIRST = {{(LED_NUM-1){1'b0}}, 1'b1};

  mode_t              active_mode;
  mode_t              mode_in;
  dir_t               dir;
  dir_t               dir_step;
  logic [31:0]        cnt;
  logic [31:0]        limit;
  logic [LED_NUM-1:0] led_step;
  logic [LED_NUM-1:0] led_start;
  logic               mode_change;
  logic               step_due;

  assign mode_in = mode_t'(mode);

  // The limit is recomputed every cycle from the live speed input. The
  // prescaler therefore follows a speed change without restarting. The >=
  // compare lets an overshot count fire on the next edge.
  assign limit       = (TICK_BASE >> speed) - 32'd1;
  assign mode_change = (mode_in != active_mode);
  assign step_due    = !pause && (cnt >= limit);

  // Start pattern for the mode being entered.
  always_comb begin
    led_start = LED_FIRST;
    if (mode_in == MODE_BLINK) begin
      led_start = '1;
    end
  end

  // Pattern and direction that the next step will show.
  // In bounce mode the direction turns as soon as an end bit lights. Each
  // end is therefore shown for a single step only.
  always_comb begin
    led_step = led;
    dir_step = dir;
    case (active_mode)
      MODE_ROTL: led_step = {led[LED_NUM-2:0], led[LED_NUM-1]};
      MODE_ROTR: led_step = {led[0], led[LED_NUM-1:1]};
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          led_step = led << 1;
          if (led_step[LED_NUM-1]) begin
            dir_step = DIR_RIGHT;
          end
        end else begin
          led_step = led >> 1;
          if (led_step[0]) begin
            dir_step = DIR_LEFT;
          end
        end
      end
      MODE_BLINK: led_step = ~led;
      default: led_step = led;
    endcase
  end

  // A mode change wins over pause and over a coincident step. It restarts
  // the interval from zero and never raises tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      led         <= LED_FIRST;
      tick        <= 1'b0;
      dir         <= DIR_LEFT;
      active_mode <= MODE_ROTL;
    end else begin
      active_mode <= mode_in;
      tick        <= 1'b0;
      if (mode_change) begin
        led <= led_start;
        cnt <= '0;
        dir <= DIR_LEFT;
      end else if (!pause) begin
        if (step_due) begin
          cnt  <= '0;
          led  <= led_step;
          dir  <= dir_step;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flow_led_ctrl.sv
// tb_flow_led_ctrl
//   Table-driven bench for flow_led_ctrl. Instance a uses LED_NUM=4 and
//   instance b uses LED_NUM=2. Both instances use TICK_CYCLES=8.
//   Each table record holds the inputs for one instance, a number of clock
//   edges to run, and the led/tick values expected after the last edge.
//   Expected values are queued when the stimulus is driven. They are popped
//   and compared once the edges have elapsed.
module tb_flow_led_ctrl;

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic [1:0] mode_a, mode_b;
  logic [1:0] speed_a, speed_b;
  logic       pause_a, pause_b;
  logic [3:0] led_a;
  logic [1:0] led_b;
  logic       tick_a, tick_b;

  flow_led_ctrl #(.LED_NUM(4), .TICK_CYCLES(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .mode  (mode_a),
    .speed (speed_a),
    .pause (pause_a),
    .led   (led_a),
    .tick  (tick_a)
  );

  flow_led_ctrl #(.LED_NUM(2), .TICK_CYCLES(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .mode  (mode_b),
    .speed (speed_b),
    .pause (pause_b),
    .led   (led_b),
    .tick  (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         dut;
    logic       rst_n;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    int         cycles;
    logic [3:0] exp_led;
    logic       exp_tick;
  } vec_t;

  typedef struct {
    string      name;
    bit         dut;
    logic [3:0] led;
    logic       tick;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   failures;

  task automatic add_vec(input string name, input bit dut, input logic r,
                         input logic [1:0] m, input logic [1:0] s,
                         input logic p, input int n,
                         input logic [3:0] el, input logic et);
    vec_t v;
    v.name = name; v.dut = dut; v.rst_n = r; v.mode = m; v.speed = s;
    v.pause = p; v.cycles = n; v.exp_led = el; v.exp_tick = et;
    vecs.push_back(v);
  endtask

  // Drive one record, queue its expectation, then let the edges elapse and
  // stop 1 time unit past the last edge.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    if (v.dut == 1'b0) begin
      rst_n_a = v.rst_n; mode_a = v.mode; speed_a = v.speed; pause_a = v.pause;
    end else begin
      rst_n_b = v.rst_n; mode_b = v.mode; speed_b = v.speed; pause_b = v.pause;
    end
    e.name = v.name; e.dut = v.dut; e.led = v.exp_led; e.tick = v.exp_tick;
    sb.push_back(e);
    repeat (v.cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_output();
    exp_t       e;
    logic [3:0] act_led;
    logic       act_tick;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      e = sb.pop_front();
      act_led  = e.dut ? {2'b00, led_b} : led_a;
      act_tick = e.dut ? tick_b : tick_a;
      if (act_led !== e.led || act_tick !== e.tick) begin
        failures++;
        $display("[TB] FAIL %s (dut %0d): led=%b tick=%b, expected led=%b tick=%b",
                 e.name, e.dut, act_led, act_tick, e.led, e.tick);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] bounce_seq [10];
    bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                   4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    checks = 0;
    failures = 0;
    rst_n_a = 1'b0; mode_a = 2'd0; speed_a = 2'd0; pause_a = 1'b0;
    rst_n_b = 1'b0; mode_b = 2'd0; speed_b = 2'd0; pause_b = 1'b0;

    //       name              dut rst mode speed pause n   led      tick
    add_vec("reset",            0, 0, 2'd0, 2'd0, 0,  2, 4'b0001, 0);
    add_vec("rotl_pre_step",    0, 1, 2'd0, 2'd0, 0,  7, 4'b0001, 0);
    add_vec("rotl_step1",       0, 1, 2'd0, 2'd0, 0,  1, 4'b0010, 1);
    add_vec("tick_one_cycle",   0, 1, 2'd0, 2'd0, 0,  1, 4'b0010, 0);
    add_vec("rotl_step2",       0, 1, 2'd0, 2'd0, 0,  7, 4'b0100, 1);
    add_vec("rotl_step3",       0, 1, 2'd0, 2'd0, 0,  8, 4'b1000, 1);
    add_vec("rotl_wrap",        0, 1, 2'd0, 2'd0, 0,  8, 4'b0001, 1);
    add_vec("rotl_step5",       0, 1, 2'd0, 2'd0, 0,  8, 4'b0010, 1);
    add_vec("rotl_mid",         0, 1, 2'd0, 2'd0, 0,  3, 4'b0010, 0);
    add_vec("reset_mid_run",    0, 0, 2'd0, 2'd0, 0,  1, 4'b0001, 0);
    add_vec("post_reset_wait",  0, 1, 2'd0, 2'd0, 0,  7, 4'b0001, 0);
    add_vec("post_reset_step",  0, 1, 2'd0, 2'd0, 0,  1, 4'b0010, 1);
    add_vec("rotr_enter",       0, 1, 2'd1, 2'd0, 0,  1, 4'b0001, 0);
    add_vec("rotr_step1",       0, 1, 2'd1, 2'd0, 0,  8, 4'b1000, 1);
    add_vec("rotr_step2",       0, 1, 2'd1, 2'd0, 0,  8, 4'b0100, 1);
    add_vec("rotr_step4",       0, 1, 2'd1, 2'd0, 0, 16, 4'b0001, 1);
    add_vec("rotr_wrap",        0, 1, 2'd1, 2'd0, 0,  8, 4'b1000, 1);
    add_vec("speed3_a",         0, 1, 2'd1, 2'd3, 0,  1, 4'b0100, 1);
    add_vec("speed3_b",         0, 1, 2'd1, 2'd3, 0,  1, 4'b0010, 1);
    add_vec("speed3_c",         0, 1, 2'd1, 2'd3, 0,  1, 4'b0001, 1);
    add_vec("bounce_enter",     0, 1, 2'd2, 2'd0, 0,  1, 4'b0001, 0);
    for (int i = 0; i < 10; i++) begin
      add_vec("bounce_step",    0, 1, 2'd2, 2'd0, 0,  8, bounce_seq[i], 1);
    end
    add_vec("blink_enter",      0, 1, 2'd3, 2'd0, 0,  1, 4'b1111, 0);
    add_vec("blink_off",        0, 1, 2'd3, 2'd0, 0,  8, 4'b0000, 1);
    add_vec("blink_on",         0, 1, 2'd3, 2'd0, 0,  8, 4'b1111, 1);
    add_vec("blink_mid",        0, 1, 2'd3, 2'd0, 0,  3, 4'b1111, 0);
    add_vec("blink_to_rotl",    0, 1, 2'd0, 2'd0, 0,  1, 4'b0001, 0);
    add_vec("rotl_restart_wait",0, 1, 2'd0, 2'd0, 0,  7, 4'b0001, 0);
    add_vec("rotl_restart_step",0, 1, 2'd0, 2'd0, 0,  1, 4'b0010, 1);
    add_vec("count_to_5",       0, 1, 2'd0, 2'd0, 0,  5, 4'b0010, 0);
    add_vec("speed_up_overrun", 0, 1, 2'd0, 2'd2, 0,  1, 4'b0100, 1);
    add_vec("speed2_gap",       0, 1, 2'd0, 2'd2, 0,  1, 4'b0100, 0);
    add_vec("speed2_step",      0, 1, 2'd0, 2'd2, 0,  1, 4'b1000, 1);
    add_vec("speed2_next",      0, 1, 2'd0, 2'd2, 0,  2, 4'b0001, 1);
    add_vec("count_to_3",       0, 1, 2'd0, 2'd0, 0,  3, 4'b0001, 0);
    add_vec("paused_20",        0, 1, 2'd0, 2'd0, 1, 20, 4'b0001, 0);
    add_vec("resume_wait",      0, 1, 2'd0, 2'd0, 0,  4, 4'b0001, 0);
    add_vec("resume_step",      0, 1, 2'd0, 2'd0, 0,  1, 4'b0010, 1);
    add_vec("mode_while_paused",0, 1, 2'd3, 2'd0, 1,  1, 4'b1111, 0);
    add_vec("paused_blink",     0, 1, 2'd3, 2'd0, 1, 10, 4'b1111, 0);
    add_vec("blink_count_7",    0, 1, 2'd3, 2'd0, 0,  7, 4'b1111, 0);
    add_vec("mode_beats_step",  0, 1, 2'd1, 2'd0, 0,  1, 4'b0001, 0);
    add_vec("rotr_after_prio",  0, 1, 2'd1, 2'd0, 0,  8, 4'b1000, 1);
    add_vec("b_reset",          1, 0, 2'd0, 2'd0, 0,  1, 4'b0001, 0);
    add_vec("b_bounce_enter",   1, 1, 2'd2, 2'd0, 0,  1, 4'b0001, 0);
    add_vec("b_bounce_step1",   1, 1, 2'd2, 2'd0, 0,  8, 4'b0010, 1);
    add_vec("b_count_to_3",     1, 1, 2'd2, 2'd0, 0,  3, 4'b0010, 0);
    add_vec("b_paused_20",      1, 1, 2'd2, 2'd0, 1, 20, 4'b0010, 0);
    add_vec("b_resume_wait",    1, 1, 2'd2, 2'd0, 0,  4, 4'b0010, 0);
    add_vec("b_bounce_step2",   1, 1, 2'd2, 2'd0, 0,  1, 4'b0001, 1);
    add_vec("b_bounce_step3",   1, 1, 2'd2, 2'd0, 0,  8, 4'b0010, 1);
    add_vec("b_bounce_step4",   1, 1, 2'd2, 2'd0, 0,  8, 4'b0001, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
